// File: rtl/scr1_dmem_resp_pkg.sv
// Shared types and helpers for the SCR1 data-memory responder.
// Carries the memif command/width/response encodings, the responder FSM
// state type, the byte-enable helper and the constants of the optional
// random-wait LFSR (feature macro: SCR1_DMEM_RESP_RAND_WAIT_EN).

`ifndef SCR1_DMEM_AWIDTH
`define SCR1_DMEM_AWIDTH 32
`endif
`ifndef SCR1_DMEM_DWIDTH
`define SCR1_DMEM_DWIDTH 32
`endif

package scr1_dmem_resp_pkg;

    // Memory interface encodings, matching the core's memif definitions
    typedef enum logic [1:0] {
        SCR1_MEM_CMD_RD    = 2'b00,
        SCR1_MEM_CMD_WR    = 2'b01,
        SCR1_MEM_CMD_ERROR = 2'b11
    } type_scr1_mem_cmd_e;

    typedef enum logic [1:0] {
        SCR1_MEM_WIDTH_BYTE  = 2'b00,
        SCR1_MEM_WIDTH_HWORD = 2'b01,
        SCR1_MEM_WIDTH_WORD  = 2'b10,
        SCR1_MEM_WIDTH_ERROR = 2'b11
    } type_scr1_mem_width_e;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_NOTRDY = 2'b00,
        SCR1_MEM_RESP_RDY_OK = 2'b01,
        SCR1_MEM_RESP_RDY_ER = 2'b10
    } type_scr1_mem_resp_e;

    // Responder FSM states
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } type_scr1_dmem_resp_fsm_e;

    // Galois LFSR, x^16 + x^14 + x^13 + x^11 + 1, right-shifting form
    localparam logic [15:0] SCR1_DMEM_RESP_LFSR_SEED = 16'hACE1;
    localparam logic [15:0] SCR1_DMEM_RESP_LFSR_TAPS = 16'hB400;

    // Byte lanes touched by an access of the given width at offset a
    function automatic logic [3:0] scr1_dmem_resp_be(
        input type_scr1_mem_width_e width,
        input logic [1:0]           a
    );
        logic [3:0] be;
        case (width)
            SCR1_MEM_WIDTH_BYTE:  be = 4'b0001 << a;
            SCR1_MEM_WIDTH_HWORD: be = 4'b0011 << a;
            SCR1_MEM_WIDTH_WORD:  be = 4'b1111;
            default:              be = 4'b0000;
        endcase
        return be;
    endfunction

    // One step of the random-wait LFSR
    function automatic logic [15:0] scr1_dmem_resp_lfsr_next(input logic [15:0] s);
        logic [15:0] n;
        n = {1'b0, s[15:1]};
        if (s[0]) begin
            n = n ^ SCR1_DMEM_RESP_LFSR_TAPS;
        end else begin
            n = n;
        end
        return n;
    endfunction

endpackage

// File: rtl/scr1_dmem_responder_if.sv
// SCR1 data-memory request/response bundle between an initiator (master)
// and the responder (slave).

`ifndef SCR1_DMEM_AWIDTH
`define SCR1_DMEM_AWIDTH 32
`endif
`ifndef SCR1_DMEM_DWIDTH
`define SCR1_DMEM_DWIDTH 32
`endif

interface scr1_dmem_responder_if;
    import scr1_dmem_resp_pkg::*;

    logic                          dmem_req;
    logic                          dmem_req_ack;
    type_scr1_mem_cmd_e            dmem_cmd;
    type_scr1_mem_width_e          dmem_width;
    logic [`SCR1_DMEM_AWIDTH-1:0]  dmem_addr;
    logic [`SCR1_DMEM_DWIDTH-1:0]  dmem_wdata;
    logic [`SCR1_DMEM_DWIDTH-1:0]  dmem_rdata;
    type_scr1_mem_resp_e           dmem_resp;

    modport master (
        output dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata,
        input  dmem_req_ack, dmem_rdata, dmem_resp
    );

    modport slave (
        input  dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata,
        output dmem_req_ack, dmem_rdata, dmem_resp
    );

endinterface

// File: rtl/scr1_dmem_resp_ram.sv
// Word-wide backing RAM for the dmem responder: byte-enabled synchronous
// write port, asynchronous read port. Contents are deliberately not reset.

module scr1_dmem_resp_ram #(
    parameter int unsigned DEPTH = 4096,
    parameter int unsigned IDX_W = 12
) (
    input  logic             clk,
    input  logic [3:0]       wr_be,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [31:0]      wr_data,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [31:0]      rd_data
);

    logic [31:0] mem_r [DEPTH];

    // Byte-lane write, one lane per enable bit
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (wr_be[b]) begin
                mem_r[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
            end
        end
    end

    assign rd_data = mem_r[rd_idx];

endmodule

// File: rtl/scr1_dmem_responder.sv
// SCR1 data-memory responder: accepts one request at a time, holds it for
// a programmable number of wait cycles, then answers RDY_OK / RDY_ER for
// one cycle while already accepting the next request.
// Optional feature macro: SCR1_DMEM_RESP_RAND_WAIT_EN adds a pseudo-random
// 0..3 extra wait cycles per request drawn from a 16-bit LFSR.

`ifndef SCR1_DMEM_AWIDTH
`define SCR1_DMEM_AWIDTH 32
`endif
`ifndef SCR1_DMEM_DWIDTH
`define SCR1_DMEM_DWIDTH 32
`endif

module scr1_dmem_responder
    import scr1_dmem_resp_pkg::*;
#(
    parameter logic [`SCR1_DMEM_AWIDTH-1:0] SCR1_MEM_BASE    = `SCR1_DMEM_AWIDTH'h00010000,
    parameter logic [31:0]                  SCR1_MEM_SIZE    = 32'h00004000,
    parameter int unsigned                  SCR1_WAIT_CYCLES = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    scr1_dmem_responder_if.slave dmem
);

    localparam int unsigned AW        = `SCR1_DMEM_AWIDTH;
    localparam int unsigned DW        = `SCR1_DMEM_DWIDTH;
    localparam int unsigned RAM_WORDS = int'(SCR1_MEM_SIZE >> 2);
    localparam int unsigned IDX_W     = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam logic [AW-1:0] RAM_SIZE_A = AW'(SCR1_MEM_SIZE);
    localparam logic [3:0]    WAIT_FIX   = (SCR1_WAIT_CYCLES > 32'd15) ? 4'd15 : 4'(SCR1_WAIT_CYCLES);

    type_scr1_dmem_resp_fsm_e state_r;
    type_scr1_dmem_resp_fsm_e state_nxt_s;
    logic [3:0]               cnt_r;
    logic [3:0]               cnt_nxt_s;
    logic [3:0]               wait_cnt_s;
    logic                     capture_s;
    logic                     req_ack_s;

    type_scr1_mem_cmd_e       cmd_r;
    type_scr1_mem_width_e     width_r;
    logic [AW-1:0]            addr_r;
    logic [DW-1:0]            wdata_r;

    logic [AW-1:0]            offset_s;
    logic                     misalign_s;
    logic                     err_s;
    logic [3:0]               wr_be_s;
    logic [IDX_W-1:0]         ram_idx_s;
    logic [31:0]              ram_rdata_s;
    type_scr1_mem_resp_e      resp_s;
    logic [DW-1:0]            rdata_s;

`ifdef SCR1_DMEM_RESP_RAND_WAIT_EN
    logic [15:0] lfsr_r;
    logic [4:0]  wait_sum_s;

    // LFSR advances once per accepted request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_r <= SCR1_DMEM_RESP_LFSR_SEED;
        end else if (capture_s) begin
            lfsr_r <= scr1_dmem_resp_lfsr_next(lfsr_r);
        end else begin
            lfsr_r <= lfsr_r;
        end
    end

    // Wait count: fixed part plus two LFSR bits, saturating at 15
    always_comb begin
        wait_sum_s = {1'b0, WAIT_FIX} + {3'b000, lfsr_r[1:0]};
        if (wait_sum_s[4]) begin
            wait_cnt_s = 4'hF;
        end else begin
            wait_cnt_s = wait_sum_s[3:0];
        end
    end
`else
    assign wait_cnt_s = WAIT_FIX;
`endif

    // FSM next state, wait counter and acceptance
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        capture_s   = 1'b0;
        req_ack_s   = 1'b0;
        case (state_r)
            IDLE, RESP: begin
                req_ack_s = 1'b1;
                if (dmem.dmem_req) begin
                    capture_s   = 1'b1;
                    cnt_nxt_s   = wait_cnt_s;
                    state_nxt_s = (wait_cnt_s != 4'd0) ? WAIT : RESP;
                end else begin
                    cnt_nxt_s   = 4'd0;
                    state_nxt_s = IDLE;
                end
            end
            WAIT: begin
                cnt_nxt_s = cnt_r - 4'd1;
                if (cnt_r <= 4'd1) begin
                    state_nxt_s = RESP;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = 4'd0;
            end
        endcase
    end

    // FSM state and wait counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Capture the request fields on acceptance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_r   <= SCR1_MEM_CMD_RD;
            width_r <= SCR1_MEM_WIDTH_BYTE;
            addr_r  <= {AW{1'b0}};
            wdata_r <= {DW{1'b0}};
        end else if (capture_s) begin
            cmd_r   <= dmem.dmem_cmd;
            width_r <= dmem.dmem_width;
            addr_r  <= dmem.dmem_addr;
            wdata_r <= dmem.dmem_wdata;
        end else begin
            cmd_r   <= cmd_r;
            width_r <= width_r;
            addr_r  <= addr_r;
            wdata_r <= wdata_r;
        end
    end

    // Error classification of the captured request; the offset is unsigned
    // so addresses below the base wrap to large values and fail the range test
    always_comb begin
        offset_s = addr_r - SCR1_MEM_BASE;
        case (width_r)
            SCR1_MEM_WIDTH_HWORD: misalign_s = addr_r[0];
            SCR1_MEM_WIDTH_WORD:  misalign_s = (addr_r[1:0] != 2'b00);
            default:              misalign_s = 1'b0;
        endcase
        err_s = ((cmd_r != SCR1_MEM_CMD_RD) && (cmd_r != SCR1_MEM_CMD_WR))
              || (width_r == SCR1_MEM_WIDTH_ERROR)
              || misalign_s
              || (offset_s >= RAM_SIZE_A);
    end

    assign ram_idx_s = offset_s[IDX_W+1:2];

    // Write lanes are enabled only in a valid write's response cycle, so the
    // RAM updates on the edge ending RESP and a reset before it drops the write
    always_comb begin
        if ((state_r == RESP) && (cmd_r == SCR1_MEM_CMD_WR) && !err_s) begin
            wr_be_s = scr1_dmem_resp_be(width_r, addr_r[1:0]);
        end else begin
            wr_be_s = 4'b0000;
        end
    end

    scr1_dmem_resp_ram #(
        .DEPTH (RAM_WORDS),
        .IDX_W (IDX_W)
    ) u_ram (
        .clk     (clk),
        .wr_be   (wr_be_s),
        .wr_idx  (ram_idx_s),
        .wr_data (wdata_r),
        .rd_idx  (ram_idx_s),
        .rd_data (ram_rdata_s)
    );

    // Response and read data, driven only during the response cycle
    always_comb begin
        resp_s  = SCR1_MEM_RESP_NOTRDY;
        rdata_s = {DW{1'b0}};
        if (state_r == RESP) begin
            if (err_s) begin
                resp_s = SCR1_MEM_RESP_RDY_ER;
            end else begin
                resp_s = SCR1_MEM_RESP_RDY_OK;
                if (cmd_r == SCR1_MEM_CMD_RD) begin
                    rdata_s = ram_rdata_s;
                end else begin
                    rdata_s = {DW{1'b0}};
                end
            end
        end else begin
            resp_s  = SCR1_MEM_RESP_NOTRDY;
            rdata_s = {DW{1'b0}};
        end
    end

    assign dmem.dmem_req_ack = req_ack_s;
    assign dmem.dmem_resp    = resp_s;
    assign dmem.dmem_rdata   = rdata_s;

endmodule

// File: tb/tb_scr1_dmem_responder.sv
// Scoreboard bench for scr1_dmem_responder: two instances (0 and 3 wait
// cycles). The driver pushes the expected response when a request is
// accepted; per-instance monitors pop and compare whenever resp != NOTRDY.

`ifndef SCR1_DMEM_AWIDTH
`define SCR1_DMEM_AWIDTH 32
`endif
`ifndef SCR1_DMEM_DWIDTH
`define SCR1_DMEM_DWIDTH 32
`endif

module tb_scr1_dmem_responder;
    import scr1_dmem_resp_pkg::*;

    typedef struct {
        type_scr1_mem_resp_e resp;
        logic [31:0]         rdata;
        bit                  ck;
        int                  acc;
        int                  lat;
        int                  id;
    } exp_t;

    logic clk = 1'b0;
    logic rst0_n = 1'b0;
    logic rst3_n = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   next_id = 0;
    int   last_wait [2];
    exp_t q0 [$];
    exp_t q3 [$];
`ifdef SCR1_DMEM_RESP_RAND_WAIT_EN
    logic [15:0] lfsr_m [2];
`endif

    scr1_dmem_responder_if bus0 ();
    scr1_dmem_responder_if bus3 ();

    scr1_dmem_responder #(.SCR1_WAIT_CYCLES(0)) dut0 (.clk(clk), .rst_n(rst0_n), .dmem(bus0));
    scr1_dmem_responder #(.SCR1_WAIT_CYCLES(3)) dut3 (.clk(clk), .rst_n(rst3_n), .dmem(bus3));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic model_reset(input int inst);
`ifdef SCR1_DMEM_RESP_RAND_WAIT_EN
        lfsr_m[inst] = 16'hACE1;
`endif
        last_wait[inst] = 0;
    endtask

    // Reference wait count for the next accepted request on an instance
    task automatic model_wait(input int inst, output int w);
`ifdef SCR1_DMEM_RESP_RAND_WAIT_EN
        logic [15:0] s;
        logic        fb;
`endif
        w = (inst == 0) ? 0 : 3;
`ifdef SCR1_DMEM_RESP_RAND_WAIT_EN
        w = w + int'(lfsr_m[inst][1:0]);
        if (w > 15) w = 15;
        s  = lfsr_m[inst];
        fb = s[0];
        s  = s >> 1;
        s[15] = s[15] ^ fb;
        s[13] = s[13] ^ fb;
        s[12] = s[12] ^ fb;
        s[10] = s[10] ^ fb;
        lfsr_m[inst] = s;
`endif
    endtask

    task automatic drive(input int inst, input logic rq, input type_scr1_mem_cmd_e c,
                         input type_scr1_mem_width_e w, input logic [31:0] a, input logic [31:0] d);
        if (inst == 0) begin
            bus0.dmem_req = rq; bus0.dmem_cmd = c; bus0.dmem_width = w;
            bus0.dmem_addr = a; bus0.dmem_wdata = d;
        end else begin
            bus3.dmem_req = rq; bus3.dmem_cmd = c; bus3.dmem_width = w;
            bus3.dmem_addr = a; bus3.dmem_wdata = d;
        end
    endtask

    function automatic logic get_ack(input int inst);
        return (inst == 0) ? bus0.dmem_req_ack : bus3.dmem_req_ack;
    endfunction

    function automatic logic [1:0] get_resp(input int inst);
        return (inst == 0) ? bus0.dmem_resp : bus3.dmem_resp;
    endfunction

    function automatic int q_size(input int inst);
        return (inst == 0) ? q0.size() : q3.size();
    endfunction

    // Present a request, wait (bounded) for acceptance, push the expectation
    task automatic issue(input int inst, input type_scr1_mem_cmd_e c, input type_scr1_mem_width_e w,
                         input logic [31:0] a, input logic [31:0] wd,
                         input type_scr1_mem_resp_e er, input logic [31:0] ed, input bit ck,
                         output int stalls);
        exp_t e;
        bit   acc;
        int   wt;
        acc = 1'b0;
        stalls = 0;
        drive(inst, 1'b1, c, w, a, wd);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (get_ack(inst)) begin
                acc = 1'b1;
                model_wait(inst, wt);
                last_wait[inst] = wt;
                e.resp = er; e.rdata = ed; e.ck = ck;
                e.acc = cyc; e.lat = 1 + wt; e.id = next_id;
                next_id++;
                if (inst == 0) q0.push_back(e); else q3.push_back(e);
            end else begin
                stalls++;
            end
            @(posedge clk); #1;
            if (acc) break;
        end
        chk($sformatf("accept i%0d addr %h", inst, a), {31'b0, acc}, 32'd1);
    endtask

    task automatic rd(input int inst, input logic [31:0] a, input logic [31:0] ed);
        int st;
        issue(inst, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, a, 32'h0, SCR1_MEM_RESP_RDY_OK, ed, 1'b1, st);
    endtask

    task automatic wr(input int inst, input type_scr1_mem_width_e w, input logic [31:0] a, input logic [31:0] d);
        int st;
        issue(inst, SCR1_MEM_CMD_WR, w, a, d, SCR1_MEM_RESP_RDY_OK, 32'h0, 1'b0, st);
    endtask

    task automatic bad(input int inst, input type_scr1_mem_cmd_e c, input type_scr1_mem_width_e w,
                       input logic [31:0] a, input logic [31:0] d);
        int st;
        issue(inst, c, w, a, d, SCR1_MEM_RESP_RDY_ER, 32'h0, 1'b1, st);
    endtask

    // Drop req and wait (bounded) until every expected response is seen
    task automatic drain(input int inst);
        drive(inst, 1'b0, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h0, 32'h0);
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (q_size(inst) == 0) break;
            @(posedge clk); #1;
        end
        chk($sformatf("drain i%0d", inst), q_size(inst), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic mon(input int inst, input type_scr1_mem_resp_e r, input logic [31:0] d);
        exp_t e;
        if (r == SCR1_MEM_RESP_NOTRDY) begin
            chk($sformatf("i%0d notrdy rdata", inst), d, 32'h0);
        end else if (q_size(inst) == 0) begin
            chk($sformatf("i%0d unexpected resp", inst), {30'b0, r}, {30'b0, SCR1_MEM_RESP_NOTRDY});
        end else begin
            if (inst == 0) e = q0.pop_front(); else e = q3.pop_front();
            chk($sformatf("i%0d #%0d resp", inst, e.id), {30'b0, r}, {30'b0, e.resp});
            chk($sformatf("i%0d #%0d latency", inst, e.id), cyc - e.acc, e.lat);
            if (e.ck) chk($sformatf("i%0d #%0d rdata", inst, e.id), d, e.rdata);
        end
    endtask

    // Monitors: compare each presented response against the scoreboard
    always @(negedge clk) if (rst0_n) mon(0, bus0.dmem_resp, bus0.dmem_rdata);
    always @(negedge clk) if (rst3_n) mon(1, bus3.dmem_resp, bus3.dmem_rdata);

    initial begin
        #100000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int st;
        int ew;
        logic [31:0] vals [4];
        vals[0] = 32'h01234567; vals[1] = 32'h89ABCDEF;
        vals[2] = 32'hFEDCBA98; vals[3] = 32'h76543210;
        model_reset(0);
        model_reset(1);
        drive(0, 1'b0, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h0, 32'h0);
        drive(1, 1'b0, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset resp", {30'b0, get_resp(0)}, {30'b0, SCR1_MEM_RESP_NOTRDY});
        chk("reset rdata", bus0.dmem_rdata, 32'h0);
        rst0_n = 1'b1;
        rst3_n = 1'b1;
        @(negedge clk);
        chk("post-reset ack0", {31'b0, get_ack(0)}, 32'd1);
        chk("post-reset ack3", {31'b0, get_ack(1)}, 32'd1);
        chk("post-reset resp3", {30'b0, get_resp(1)}, {30'b0, SCR1_MEM_RESP_NOTRDY});
        @(posedge clk); #1;

        // Write then read accepted in the write's response cycle
        issue(0, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h00010010, 32'hDEADBEEF,
              SCR1_MEM_RESP_RDY_OK, 32'h0, 1'b0, st);
        chk("wr ack stalls", st, 32'd0);
        ew = last_wait[0];
        issue(0, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h00010010, 32'h0,
              SCR1_MEM_RESP_RDY_OK, 32'hDEADBEEF, 1'b1, st);
        chk("raw rd ack stalls", st, ew);
        drain(0);

        // Byte and halfword merges
        wr(0, SCR1_MEM_WIDTH_WORD, 32'h00010010, 32'h11223344);
        wr(0, SCR1_MEM_WIDTH_BYTE, 32'h00010013, 32'h5A000000);
        rd(0, 32'h00010010, 32'h5A223344);
        wr(0, SCR1_MEM_WIDTH_WORD, 32'h00010004, 32'h11111111);
        wr(0, SCR1_MEM_WIDTH_HWORD, 32'h00010006, 32'hBEEF0000);
        wr(0, SCR1_MEM_WIDTH_BYTE, 32'h00010004, 32'h000000C3);
        rd(0, 32'h00010004, 32'hBEEF11C3);
        drain(0);

        // Error classification; follow-up reads prove no write happened
        wr(0, SCR1_MEM_WIDTH_WORD, 32'h00010000, 32'hA5A5A5A5);
        wr(0, SCR1_MEM_WIDTH_WORD, 32'h00013FFC, 32'h0F0F0F0F);
        bad(0, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_HWORD, 32'h00010001, 32'h0);
        rd(0, 32'h00010000, 32'hA5A5A5A5);
        bad(0, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h00014000, 32'hBAD0BAD0);
        rd(0, 32'h00010000, 32'hA5A5A5A5);
        bad(0, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h0000FFFC, 32'h0);
        bad(0, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h0000FFFC, 32'hBAD2BAD2);
        rd(0, 32'h00013FFC, 32'h0F0F0F0F);
        bad(0, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h00010002, 32'hBAD1BAD1);
        bad(0, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_ERROR, 32'h00010000, 32'hBAD3BAD3);
        bad(0, SCR1_MEM_CMD_ERROR, SCR1_MEM_WIDTH_WORD, 32'h00010000, 32'hBAD4BAD4);
        rd(0, 32'h00010000, 32'hA5A5A5A5);
        drain(0);

        // Three wait cycles: req held high is not acknowledged during WAIT
        wr(1, SCR1_MEM_WIDTH_WORD, 32'h00010040, 32'h77665544);
        drain(1);
        issue(1, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h00010040, 32'h0,
              SCR1_MEM_RESP_RDY_OK, 32'h77665544, 1'b1, st);
        chk("w3 first ack stalls", st, 32'd0);
        ew = last_wait[1];
        issue(1, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h00010040, 32'h0,
              SCR1_MEM_RESP_RDY_OK, 32'h77665544, 1'b1, st);
        chk("w3 held req stalls", st, ew);
        drain(1);

        // Reset during WAIT drops a pending write
        wr(1, SCR1_MEM_WIDTH_WORD, 32'h00010020, 32'hCAFEF00D);
        drain(1);
        wr(1, SCR1_MEM_WIDTH_WORD, 32'h00010020, 32'h12345678);
        drive(1, 1'b0, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h0, 32'h0);
        @(negedge clk);
        rst3_n = 1'b0;
        q3.delete();
        model_reset(1);
        @(posedge clk);
        @(negedge clk);
        rst3_n = 1'b1;
        @(negedge clk);
        chk("rst mid-wait resp", {30'b0, get_resp(1)}, {30'b0, SCR1_MEM_RESP_NOTRDY});
        chk("rst mid-wait ack", {31'b0, get_ack(1)}, 32'd1);
        @(posedge clk); #1;
        rd(1, 32'h00010020, 32'hCAFEF00D);
        drain(1);

        // 64 back-to-back reads
        for (int i = 0; i < 4; i++) wr(0, SCR1_MEM_WIDTH_WORD, 32'h00010100 + 32'(4 * i), vals[i]);
        drain(0);
        for (int i = 0; i < 64; i++) rd(0, 32'h00010100 + 32'(4 * (i % 4)), vals[i % 4]);
        drain(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
